// File: rtl/lutram_mp.sv
// lutram_mp: multi-read-port distributed RAM with byte-strobed writes,
// selectable read latency, optional write forwarding and a hardware clear sequencer.
module lutram_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int NUM_READ     = 2,
  parameter int READ_LATENCY = 0,
  parameter int BYPASS       = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           en,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH/8-1:0]        strobe,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  input  logic                           clear_req,
  output logic                           busy
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cptr_q, cptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wmask;
  logic wr;
  assign busy = state_q == CLEAR;
  assign wr = resetn && !busy && en;
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH/8; i++) wmask[8*i +: 8] = {8{strobe[i]}};
  end
  // The pointer wraps to 0 on the last entry, so it is ready for the next clear.
  always_comb begin
    state_d = state_q;
    cptr_d = cptr_q;
    if (state_q == CLEAR) begin
      cptr_d = cptr_q + 1'b1;
      state_d = &cptr_q ? READY : CLEAR;
    end else if (clear_req) begin
      state_d = CLEAR;
      cptr_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= CLEAR;
      cptr_q <= '0;
    end else begin
      state_q <= state_d;
      cptr_q <= cptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (resetn && busy) mem_q[cptr_q] <= '0;
    else if (wr) mem_q[waddr] <= (mem_q[waddr] & ~wmask) | (wdata & wmask);
  end
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd = mem_q[ra];
    if (READ_LATENCY == 0) begin : g_async
      assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = busy ? '0 : rd;
    end else begin : g_sync
      logic [DATA_WIDTH-1:0] rdata_q, fwd;
      assign fwd = (BYPASS != 0 && wr && waddr == ra) ? (rd & ~wmask) | (wdata & wmask) : rd;
      always_ff @(posedge clk) begin
        if (!resetn || busy) rdata_q <= '0;
        else rdata_q <= fwd;
      end
      assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end
  end
endmodule

// File: tb/tb_lutram_mp.sv
// tb_lutram_mp: directed table-driven bench for lutram_mp, comparing async, bypassed and
// non-bypassed registered instances driven by the same stimulus.
module tb_lutram_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, en, clear_req;
  logic [3:0] waddr, strobe;
  logic [31:0] wdata;
  logic [7:0] raddr;
  logic [63:0] rd0, rd1, rd2;
  logic b0, b1, b2;
  int n_cmp = 0, n_bad = 0;
  lutram_mp #(.READ_LATENCY(0)) u0 (.clk(clk), .resetn(resetn), .en(en), .waddr(waddr), .strobe(strobe),
    .wdata(wdata), .raddr(raddr), .rdata(rd0), .clear_req(clear_req), .busy(b0));
  lutram_mp #(.READ_LATENCY(1), .BYPASS(1)) u1 (.clk(clk), .resetn(resetn), .en(en), .waddr(waddr),
    .strobe(strobe), .wdata(wdata), .raddr(raddr), .rdata(rd1), .clear_req(clear_req), .busy(b1));
  lutram_mp #(.READ_LATENCY(1), .BYPASS(0)) u2 (.clk(clk), .resetn(resetn), .en(en), .waddr(waddr),
    .strobe(strobe), .wdata(wdata), .raddr(raddr), .rdata(rd2), .clear_req(clear_req), .busy(b2));
  typedef struct {
    logic en;
    logic [3:0] wa, st, ra0, ra1;
    logic [31:0] wd, e0, e1;
  } vec_t;
  vec_t tbl[7];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic wait_clear(input string nm);
    int n = 0;
    while (b0 && n < 100) begin
      tick();
      n++;
    end
    chk(nm, 32'(n), 32'd16);
  endtask
  task automatic check_zero(input string nm);
    for (int a = 0; a < 16; a++) begin
      raddr = {4'(15 - a), 4'(a)};
      tick();
      chk({nm, "_p0"}, rd0[31:0], 32'h0);
      chk({nm, "_p1"}, rd0[63:32], 32'h0);
      chk({nm, "_reg"}, rd1[31:0], 32'h0);
    end
  endtask
  initial begin
    int n;
    tbl[0] = '{en: 1, wa: 0,  st: 4'hf, wd: 32'hdeadbeef, ra0: 0,  ra1: 15, e0: 32'hdeadbeef, e1: 32'h0};
    tbl[1] = '{en: 1, wa: 15, st: 4'h5, wd: 32'hcccccccc, ra0: 0,  ra1: 15, e0: 32'hdeadbeef, e1: 32'h00cc00cc};
    tbl[2] = '{en: 1, wa: 14, st: 4'ha, wd: 32'h12345678, ra0: 14, ra1: 15, e0: 32'h12005600, e1: 32'h00cc00cc};
    tbl[3] = '{en: 0, wa: 14, st: 4'hf, wd: 32'hacacacac, ra0: 14, ra1: 14, e0: 32'h12005600, e1: 32'h12005600};
    tbl[4] = '{en: 1, wa: 14, st: 4'h0, wd: 32'h55aa55aa, ra0: 14, ra1: 0,  e0: 32'h12005600, e1: 32'hdeadbeef};
    tbl[5] = '{en: 1, wa: 3,  st: 4'hf, wd: 32'h11223344, ra0: 3,  ra1: 2,  e0: 32'h11223344, e1: 32'h0};
    tbl[6] = '{en: 1, wa: 7,  st: 4'h8, wd: 32'hffffffff, ra0: 7,  ra1: 3,  e0: 32'hff000000, e1: 32'h11223344};
    resetn = 0; en = 0; clear_req = 0; waddr = 0; strobe = 0; wdata = 0; raddr = 0;
    tick();
    tick();
    chk("rst_busy", 32'(b0), 32'd1);
    chk("rst_rdata_reg", rd1[31:0], 32'h0);
    chk("rst_rdata_nobyp", rd2[63:32], 32'h0);
    resetn = 1;
    #1;
    chk("busy_read_zero", rd0[31:0], 32'h0);
    wait_clear("reset_busy_len");
    chk("busy_low_reg", 32'(b1 | b2), 32'd0);
    check_zero("post_reset");
    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en; waddr = tbl[i].wa; strobe = tbl[i].st; wdata = tbl[i].wd;
      raddr = {tbl[i].ra1, tbl[i].ra0};
      tick();
      en = 0;
      chk($sformatf("vec%0d_p0", i), rd0[31:0], tbl[i].e0);
      chk($sformatf("vec%0d_p1", i), rd0[63:32], tbl[i].e1);
      chk($sformatf("vec%0d_reg_p0", i), rd1[31:0], tbl[i].e0);
      chk($sformatf("vec%0d_reg_p1", i), rd1[63:32], tbl[i].e1);
    end
    raddr = {4'd3, 4'd0};
    en = 1; waddr = 3; strobe = 4'h3; wdata = 32'haabbccdd;
    tick();
    en = 0;
    chk("byp_async", rd0[63:32], 32'h1122ccdd);
    chk("byp_on", rd1[63:32], 32'h1122ccdd);
    chk("byp_off_old", rd2[63:32], 32'h11223344);
    tick();
    chk("byp_off_next", rd2[63:32], 32'h1122ccdd);
    clear_req = 1; en = 1; waddr = 5; strobe = 4'hf; wdata = 32'hffffffff;
    tick();
    clear_req = 0; en = 0;
    chk("clr_busy_rise", 32'(b0), 32'd1);
    n = 0;
    while (b0 && n < 100) begin
      en = (n == 4);
      waddr = 0; strobe = 4'hf; wdata = 32'h99999999;
      clear_req = (n == 10);
      tick();
      n++;
    end
    en = 0; clear_req = 0;
    chk("clr_busy_len", 32'(n), 32'd16);
    check_zero("post_clear");
    en = 1; waddr = 9; strobe = 4'hf; wdata = 32'h5a5a5a5a; raddr = {4'd9, 4'd9};
    tick();
    en = 0;
    chk("pre_rst_write", rd0[31:0], 32'h5a5a5a5a);
    clear_req = 1;
    tick();
    clear_req = 0;
    repeat (7) tick();
    chk("mid_clear_busy", 32'(b0), 32'd1);
    resetn = 0;
    tick();
    chk("mid_rst_busy", 32'(b0), 32'd1);
    resetn = 1;
    wait_clear("rst_mid_clear_len");
    check_zero("post_mid_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
